// File: rtl/dmem_dma_pkg.sv
// rtl/dmem_dma_pkg.sv - shared types and constants for the dmem/DMA arbiter
package dmem_dma_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD,
        WR,
        DONE
    } dma_state_t;

endpackage

// File: rtl/dmem_dma_arbiter_if.sv
// rtl/dmem_dma_arbiter_if.sv - data-memory port bundle (master = arbiter, slave = dmem)
// Signals: mem_we, mem_addr, mem_wdata driven by the master; mem_rdata is the
// combinational read data returned by the slave.
interface dmem_dma_arbiter_if;
    import dmem_dma_pkg::*;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);

endinterface

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - DMA source/destination/count registers and last-word flag
// Ports: clk, reset (async active-low); load latches src_in/dst_in/len_in with
// the low two address bits cleared; step advances both addresses by one word
// and decrements the count. len_zero flags an empty transfer, last flags the
// final word (count == 1).
module dma_addr_gen
    import dmem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic              len_zero,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src   <= '0;
            dst   <= '0;
            count <= '0;
        end else if (load) begin
            src   <= src_in & ALIGN_MASK;
            dst   <= dst_in & ALIGN_MASK;
            count <= len_in;
        end else if (step) begin
            // 32-bit adds wrap naturally past 0xFFFFFFFC
            src   <= src + ADDR_W'(WORD_BYTES);
            dst   <= dst + ADDR_W'(WORD_BYTES);
            count <= count - LEN_W'(1);
        end
    end

    assign len_zero = (count == '0);
    assign last     = (count == LEN_W'(1));

endmodule

// File: rtl/dmem_dma_arbiter.sv
// rtl/dmem_dma_arbiter.sv - shares dmem between the core (absolute priority) and a word-copy DMA
// Ports: clk, reset (async active-low); core_req/core_we/core_addr/core_wdata
// from the core, core_rdata back to it; dma_start/dma_src/dma_dst/dma_len/
// dma_fill/dma_pattern launch a transfer, dma_busy/dma_done report status;
// mem (dmem_dma_arbiter_if.master) is the shared dmem port.
// Build option: DMEM_DMA_FILL_EN enables fill mode (dma_fill/dma_pattern);
// without it those inputs are ignored and every transfer is a copy.
module dmem_dma_arbiter
    import dmem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [ADDR_W-1:0]  core_addr,
    input  logic [31:0]        core_wdata,
    output logic [31:0]        core_rdata,
    input  logic               dma_start,
    input  logic [ADDR_W-1:0]  dma_src,
    input  logic [ADDR_W-1:0]  dma_dst,
    input  logic [LEN_W-1:0]   dma_len,
    input  logic               dma_fill,
    input  logic [31:0]        dma_pattern,
    output logic               dma_busy,
    output logic               dma_done,
    dmem_dma_arbiter_if.master mem
);

    dma_state_t        state;
    logic [31:0]       buf_q;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic              len_zero;
    logic              last;
    logic              granted;
    logic              start_ok;
    logic [31:0]       wr_data;

    // The DMA may only touch the port in cycles where the core is silent.
    assign granted  = !core_req;
    assign start_ok = (state == IDLE) && dma_start;

`ifdef DMEM_DMA_FILL_EN
    logic fill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= 1'b0;
        end else if (start_ok) begin
            fill_q <= dma_fill;
        end
    end

    assign wr_data = fill_q ? dma_pattern : buf_q;
`else
    localparam logic fill_q = 1'b0;
    logic unused_fill_inputs;

    assign unused_fill_inputs = dma_fill ^ (^dma_pattern);
    assign wr_data            = buf_q;
`endif

    dma_addr_gen #(
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (start_ok),
        .step     ((state == WR) && granted),
        .src_in   (dma_src),
        .dst_in   (dma_dst),
        .len_in   (dma_len),
        .src      (src),
        .dst      (dst),
        .len_zero (len_zero),
        .last     (last)
    );

    // dma_busy/dma_done are kept as registers so they track state exactly:
    // busy rises on entry to LOAD and falls on leaving DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            buf_q    <= '0;
            dma_busy <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_start) begin
                        state    <= LOAD;
                        dma_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (len_zero) begin
                        state    <= DONE;
                        dma_done <= 1'b1;
                    end else begin
                        state <= fill_q ? WR : RD;
                    end
                end
                RD: begin
                    if (granted) begin
                        buf_q <= mem.mem_rdata;
                        state <= WR;
                    end
                end
                WR: begin
                    if (granted) begin
                        if (last) begin
                            state    <= DONE;
                            dma_done <= 1'b1;
                        end else begin
                            state <= fill_q ? WR : RD;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    dma_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    dma_busy <= 1'b0;
                end
            endcase
        end
    end

    // Core signals are the default owner so core reads stay transparent.
    always_comb begin
        mem.mem_we    = core_we;
        mem.mem_addr  = core_addr;
        mem.mem_wdata = core_wdata;
        if (granted) begin
            if (state == RD) begin
                mem.mem_we   = 1'b0;
                mem.mem_addr = src;
            end else if (state == WR) begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = dst;
                mem.mem_wdata = wr_data;
            end
        end
    end

    assign core_rdata = mem.mem_rdata;

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// tb/tb_dmem_dma_arbiter.sv - directed self-checking bench for dmem_dma_arbiter
module tb_dmem_dma_arbiter;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        dma_start;
    logic [31:0] dma_src;
    logic [31:0] dma_dst;
    logic [15:0] dma_len;
    logic        dma_fill;
    logic [31:0] dma_pattern;
    logic        dma_busy;
    logic        dma_done;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;
    int wr_base;
    int cyc;

    logic [31:0] mem_arr [0:255];

    dmem_dma_arbiter_if bus ();

    dmem_dma_arbiter #(.LEN_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .dma_start   (dma_start),
        .dma_src     (dma_src),
        .dma_dst     (dma_dst),
        .dma_len     (dma_len),
        .dma_fill    (dma_fill),
        .dma_pattern (dma_pattern),
        .dma_busy    (dma_busy),
        .dma_done    (dma_done),
        .mem         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-indexed memory; 256 words alias so wrapped addresses land at low indices.
    assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
            wr_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle k=0 is the start-pulse cycle. The core stores 0xAA at 0x10 in cycles
    // rq_lo..rq_hi; a second start with dst 0x180 is pulsed in cycle restart_k.
    task automatic run(input int rq_lo, input int rq_hi, input int restart_k, output int done_k);
        bit fin;
        done_k = -1;
        fin = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            dma_start  = (k == 0) || (k == restart_k);
            if (k == restart_k) dma_dst = 32'h180;
            core_req   = (k >= rq_lo) && (k <= rq_hi);
            core_we    = core_req;
            core_addr  = core_req ? 32'h10 : 32'h0;
            core_wdata = 32'hAA;
            @(negedge clk);
            if (core_req) begin
                check("core_owns_addr", bus.mem_addr, 32'h10);
                check("core_holds_busy", {31'd0, dma_busy}, 32'd1);
            end
            if (dma_done) begin
                done_k = k;
                fin = 1'b1;
            end
            tick();
        end
        dma_start = 1'b0;
        core_req  = 1'b0;
        core_we   = 1'b0;
        core_addr = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[16] = 32'h11;
        mem_arr[17] = 32'h22;
        mem_arr[18] = 32'h33;
        reset = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        dma_start = 1'b0; dma_src = 32'h0; dma_dst = 32'h0; dma_len = 16'd0;
        dma_fill = 1'b0; dma_pattern = 32'h0;
        tick();
        check("rst_busy", {31'd0, dma_busy}, 32'd0);
        check("rst_done", {31'd0, dma_done}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Core read transparency while DMA idle
        core_addr = 32'h44;
        #1;
        check("core_rdata", core_rdata, 32'h22);
        core_addr = 32'h0;

        // Basic copy, len=3
        dma_src = 32'h40; dma_dst = 32'h80; dma_len = 16'd3;
        wr_base = wr_count;
        run(1, 0, -1, cyc);
        check("copy_done_cyc", 32'(cyc), 32'd8);
        check("copy_w0", mem_arr[32], 32'h11);
        check("copy_w1", mem_arr[33], 32'h22);
        check("copy_w2", mem_arr[34], 32'h33);
        check("copy_wr_count", 32'(wr_count - wr_base), 32'd3);
        check("copy_idle_busy", {31'd0, dma_busy}, 32'd0);

        // len=0: no memory write, done two cycles after start
        dma_dst = 32'h90; dma_len = 16'd0;
        wr_base = wr_count;
        run(1, 0, -1, cyc);
        check("len0_done_cyc", 32'(cyc), 32'd2);
        check("len0_wr_count", 32'(wr_count - wr_base), 32'd0);

        // Core collides for 5 cycles over RD/WR
        dma_src = 32'h40; dma_dst = 32'hC0; dma_len = 16'd2;
        wr_base = wr_count;
        run(2, 6, -1, cyc);
        check("coll_done_cyc", 32'(cyc), 32'd11);
        check("coll_core_word", mem_arr[4], 32'hAA);
        check("coll_w0", mem_arr[48], 32'h11);
        check("coll_w1", mem_arr[49], 32'h22);
        check("coll_wr_count", 32'(wr_count - wr_base), 32'd7);

        // Reset while in WR of a 3-word copy
        dma_src = 32'h40; dma_dst = 32'h100; dma_len = 16'd3;
        dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
        tick();
        tick();
        check("mid_wr_we", {31'd0, bus.mem_we}, 32'd1);
        check("mid_wr_addr", bus.mem_addr, 32'h100);
        wr_base = wr_count;
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, dma_busy}, 32'd0);
        check("rst_mid_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_wr_count", 32'(wr_count - wr_base), 32'd0);
        check("rst_mid_mem", mem_arr[64], 32'h0);
        dma_src = 32'h48; dma_dst = 32'h100; dma_len = 16'd1;
        run(1, 0, -1, cyc);
        check("post_rst_done_cyc", 32'(cyc), 32'd4);
        check("post_rst_mem", mem_arr[64], 32'h33);

        // Start while busy is ignored
        dma_src = 32'h40; dma_dst = 32'h140; dma_len = 16'd2;
        run(1, 0, 3, cyc);
        check("busy_start_cyc", 32'(cyc), 32'd6);
        check("busy_start_w0", mem_arr[80], 32'h11);
        check("busy_start_w1", mem_arr[81], 32'h22);
        check("busy_start_other", mem_arr[96], 32'h0);
        tick();
        check("busy_start_idle", {31'd0, dma_busy}, 32'd0);

`ifdef DMEM_DMA_FILL_EN
        // Fill with address wrap past 0xFFFFFFFC
        dma_fill = 1'b1; dma_pattern = 32'hDEADBEEF;
        dma_dst = 32'hFFFF_FFF8; dma_len = 16'd3;
        wr_base = wr_count;
        run(1, 0, -1, cyc);
        dma_fill = 1'b0;
        check("fill_done_cyc", 32'(cyc), 32'd5);
        check("fill_w0", mem_arr[254], 32'hDEADBEEF);
        check("fill_w1", mem_arr[255], 32'hDEADBEEF);
        check("fill_w2", mem_arr[0], 32'hDEADBEEF);
        check("fill_wr_count", 32'(wr_count - wr_base), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
